// File: rtl/key_segment_io.sv
// Board I/O front end: 4x4 keypad scanner with frame-based debounce feeding a
// 16-bit key-entry shift register, plus an 8-digit multiplexed 7-segment driver.
module key_segment_io #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 4,
  parameter int DISP_DIV   = 50000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  KEY_R,
  output logic [3:0]  KEY_C,
  output logic [15:0] out,
  output logic [2:0]  press_times,
  output logic        key_valid,
  input  logic [31:0] N,
  output logic [7:0]  seg,
  output logic [2:0]  sel
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DISP_W = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
  localparam int DEB_W  = $clog2(DEB_FRAMES + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_FULL  = DEB_W'(DEB_FRAMES);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

  // Frame keys carry a fifth bit so NONE (16) orders above every real code,
  // which lets "lowest pressed code wins" be a plain magnitude compare.
  localparam logic [4:0] KEY_NONE = 5'h10;

  typedef enum logic {ST_IDLE, ST_HELD} press_state_t;

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_col;
  logic [4:0]        r_frame_acc;
  logic [4:0]        r_prev_key;
  logic [DEB_W-1:0]  r_stable_cnt;
  press_state_t      r_state;
  logic [15:0]       r_out;
  logic [2:0]        r_press_times;
  logic              r_key_valid;
  logic [DISP_W-1:0] r_ref_cnt;
  logic [2:0]        r_sel;
  logic [7:0]        r_seg;

  logic              w_sample;
  logic              w_frame_end;
  logic              w_stable_full;
  logic [4:0]        w_col_code;
  logic [4:0]        w_frame_key;
  logic [2:0]        w_next_sel;
  logic [3:0]        w_digit;

  function automatic logic [7:0] hex_font(input logic [3:0] v);
    logic [7:0] p;
    case (v)
      4'h0: p = 8'h3F;
      4'h1: p = 8'h06;
      4'h2: p = 8'h5B;
      4'h3: p = 8'h4F;
      4'h4: p = 8'h66;
      4'h5: p = 8'h6D;
      4'h6: p = 8'h7D;
      4'h7: p = 8'h07;
      4'h8: p = 8'h7F;
      4'h9: p = 8'h6F;
      4'hA: p = 8'h77;
      4'hB: p = 8'h7C;
      4'hC: p = 8'h39;
      4'hD: p = 8'h5E;
      4'hE: p = 8'h79;
      default: p = 8'h71;
    endcase
    return p;
  endfunction

  assign w_sample      = (r_scan_cnt == SCAN_LAST);
  assign w_frame_end   = w_sample && (r_col == 2'd0);
  assign w_stable_full = (r_stable_cnt == DEB_FULL);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it holding state (no latch inferred).
  always_comb begin
    w_col_code = KEY_NONE;
    // Scan high row to low so the lowest pressed row is the last one written.
    for (int r = 3; r >= 0; r--) begin
      if (!KEY_R[r]) w_col_code = {1'b0, 2'(r), r_col};
    end
    w_frame_key = (w_col_code < r_frame_acc) ? w_col_code : r_frame_acc;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_scan_cnt   <= '0;
      r_col        <= 2'd3;
      r_frame_acc  <= KEY_NONE;
      r_prev_key   <= KEY_NONE;
      r_stable_cnt <= '0;
    end else if (w_sample) begin
      r_scan_cnt <= '0;
      r_col      <= r_col - 2'd1;
      if (w_frame_end) begin
        r_frame_acc <= KEY_NONE;
        r_prev_key  <= w_frame_key;
        if (w_frame_key != r_prev_key) r_stable_cnt <= DEB_ONE;
        else if (!w_stable_full)       r_stable_cnt <= r_stable_cnt + DEB_ONE;
      end else begin
        r_frame_acc <= w_frame_key;
      end
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Press FSM acts one cycle after the frame that made the count saturate.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state       <= ST_IDLE;
      r_out         <= '0;
      r_press_times <= '0;
      r_key_valid   <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_stable_full && (r_prev_key != KEY_NONE)) begin
            r_state       <= ST_HELD;
            r_out         <= {r_out[11:0], r_prev_key[3:0]};
            r_press_times <= r_press_times + 3'd1;
            r_key_valid   <= 1'b1;
          end
        end
        ST_HELD: begin
          if (w_stable_full && (r_prev_key == KEY_NONE)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_next_sel = r_sel + 3'd1;
  assign w_digit    = N[{w_next_sel, 2'b00} +: 4];

  // sel and seg load together so the pattern always matches the lit digit.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_ref_cnt <= '0;
      r_sel     <= '0;
      r_seg     <= '0;
    end else if (r_ref_cnt == DISP_LAST) begin
      r_ref_cnt <= '0;
      r_sel     <= w_next_sel;
      r_seg     <= hex_font(w_digit);
    end else begin
      r_ref_cnt <= r_ref_cnt + DISP_W'(1);
    end
  end

  assign KEY_C       = ~(4'b0001 << r_col);
  assign out         = r_out;
  assign press_times = r_press_times;
  assign key_valid   = r_key_valid;
  assign seg         = r_seg;
  assign sel         = r_sel;

endmodule

// File: tb/tb_key_segment_io.sv
// Self-checking bench for key_segment_io: directed and random key/display
// stimulus compared every cycle against a frame-level behavioural model.
module tb_key_segment_io;

  localparam int S     = 4;
  localparam int DEB   = 2;
  localparam int D     = 4;
  localparam int FRAME = 4 * S;
  localparam int NONE  = 16;

  localparam logic [7:0] FONT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  // Expected patterns for N = 0x1234ABCD, indexed by digit.
  localparam logic [7:0] DISP_EXP [8] = '{
    8'h5E, 8'h39, 8'h7C, 8'h77, 8'h66, 8'h4F, 8'h5B, 8'h06
  };

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  KEY_R;
  logic [3:0]  KEY_C;
  logic [15:0] out;
  logic [2:0]  press_times;
  logic        key_valid;
  logic [31:0] N = '0;
  logic [7:0]  seg;
  logic [2:0]  sel;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int dut_kv = 0;

  // Behavioural model state.
  int          m_cyc;
  int          m_codes[$];
  int          m_prev;
  int          m_stable;
  bit          m_held;
  bit          m_due;
  logic [3:0]  m_due_code;
  logic [15:0] m_out;
  int          m_pt;
  bit          m_kv;
  int          m_sel;
  logic [7:0]  m_seg;

  key_segment_io #(.SCAN_DIV(S), .DEB_FRAMES(DEB), .DISP_DIV(D)) dut (
    .clk(clk), .clr(clr), .KEY_R(KEY_R), .KEY_C(KEY_C), .out(out),
    .press_times(press_times), .key_valid(key_valid), .N(N), .seg(seg), .sel(sel)
  );

  always #5 clk = ~clk;

  // Physical keypad: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    KEY_R = 4'hF;
    for (int r = 0; r < 4; r++) KEY_R[r] = ~|(keys[4*r +: 4] & ~KEY_C);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic model_edge();
    int c, col, fk;
    if (!clr) begin
      m_cyc = 0; m_codes.delete(); m_prev = NONE; m_stable = 0; m_held = 0;
      m_due = 0; m_out = '0; m_pt = 0; m_kv = 0; m_sel = 0; m_seg = '0;
      return;
    end
    c    = m_cyc;
    m_kv = 0;
    if (m_due) begin
      m_due = 0;
      m_kv  = 1;
      m_out = {m_out[11:0], m_due_code};
      m_pt  = (m_pt + 1) % 8;
    end
    if (c % S == S - 1) begin
      col = 3 - ((c / S) % 4);
      for (int r = 0; r < 4; r++) if (keys[4*r + col]) m_codes.push_back(4*r + col);
      if (col == 0) begin
        fk = NONE;
        foreach (m_codes[i]) if (m_codes[i] < fk) fk = m_codes[i];
        m_codes.delete();
        m_stable = (fk == m_prev) ? ((m_stable + 1 > DEB) ? DEB : m_stable + 1) : 1;
        m_prev   = fk;
        if (m_stable == DEB) begin
          if (!m_held && fk != NONE) begin
            m_held = 1; m_due = 1; m_due_code = 4'(fk);
          end else if (m_held && fk == NONE) begin
            m_held = 0;
          end
        end
      end
    end
    if (c % D == D - 1) begin
      m_sel = (m_sel + 1) % 8;
      m_seg = FONT[N[4*m_sel +: 4]];
    end
    m_cyc++;
  endtask

  task automatic step();
    logic [3:0] exp_keyc;
    @(posedge clk);
    model_edge();
    #1;
    exp_keyc = ~(4'b0001 << (3 - ((m_cyc / S) % 4)));
    check("KEY_C", 32'(KEY_C), 32'(exp_keyc));
    check("key_valid", 32'(key_valid), 32'(m_kv));
    check("out", 32'(out), 32'(m_out));
    check("press_times", 32'(press_times), 32'(m_pt));
    check("sel", 32'(sel), 32'(m_sel));
    check("seg", 32'(seg), 32'(m_seg));
    if (key_valid === 1'b1) dut_kv++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int kv0, first_sel, k;

    // Reset held for three cycles.
    clr = 1'b0;
    run(3);
    clr = 1'b1;
    check("rst_keyc", 32'(KEY_C), 32'h7);
    check("rst_out", 32'(out), 32'h0);
    check("rst_pt", 32'(press_times), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    run(4);
    check("scan_advance", 32'(KEY_C), 32'hB);

    // Single press: row 1 pulled low while column 2 is driven.
    while (((m_cyc / S) % 4) != 1) step();
    kv0  = dut_kv;
    keys = 16'h0040;
    run(5 * FRAME);
    keys = '0;
    run(3 * FRAME + 2);
    check("single_pulses", 32'(dut_kv - kv0), 32'd1);
    check("single_out", 32'(out), 32'h0006);
    check("single_pt", 32'(press_times), 32'd1);

    // Sequence 1..5 from a fresh reset.
    clr = 1'b0;
    run(2);
    clr = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      keys = 16'(1 << i);
      run(3 * FRAME + 2);
      keys = '0;
      run(3 * FRAME + 2);
    end
    check("seq_out", 32'(out), 32'h2345);
    check("seq_pt", 32'(press_times), 32'd5);

    // Bounce: key toggles every frame, then released.
    kv0 = dut_kv;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0080 : 16'h0000;
      run(FRAME);
    end
    keys = '0;
    run(3 * FRAME);
    check("bounce_pulses", 32'(dut_kv - kv0), 32'd0);

    // Two keys together: lowest code wins, accepted once.
    kv0  = dut_kv;
    keys = 16'h0208;
    run(4 * FRAME);
    keys = '0;
    run(3 * FRAME + 2);
    check("dual_pulses", 32'(dut_kv - kv0), 32'd1);
    check("dual_code", 32'(out[3:0]), 32'h3);

    // Display walk over all eight digits including the 7 -> 0 wrap.
    N = 32'h1234ABCD;
    run(9 * D);
    do step(); while (m_cyc % D != 0);
    first_sel = m_sel;
    for (int i = 0; i < 9; i++) begin
      check("disp_sel", 32'(sel), 32'((first_sel + i) % 8));
      check("disp_seg", 32'(seg), 32'(DISP_EXP[(first_sel + i) % 8]));
      run(D);
    end

    // Reset while a key is held: it must re-qualify from scratch.
    keys = 16'h0020;
    kv0  = dut_kv;
    run(3 * FRAME + 2);
    check("held_pre_pulses", 32'(dut_kv - kv0), 32'd1);
    clr = 1'b0;
    run(2);
    clr = 1'b1;
    kv0 = dut_kv;
    run(2 * FRAME);
    check("held_rst_quiet", 32'(dut_kv - kv0), 32'd0);
    run(FRAME);
    check("held_rst_accept", 32'(dut_kv - kv0), 32'd1);
    check("held_rst_out", 32'(out), 32'h0005);
    keys = '0;
    run(3 * FRAME + 2);

    // Randomized presses, chords and display words.
    for (int i = 0; i < 20; i++) begin
      k    = $urandom_range(0, 15);
      keys = 16'(1 << k);
      if ($urandom_range(0, 3) == 0) keys = keys | 16'(1 << $urandom_range(0, 15));
      N = $urandom;
      run($urandom_range(1, 4) * FRAME + $urandom_range(0, FRAME - 1));
      keys = '0;
      run($urandom_range(1, 4) * FRAME + $urandom_range(0, FRAME - 1));
    end
    run(3 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_segment_io.md
# key_segment_io

Board I/O front end combining a 4x4 matrix-keypad scanner and an 8-digit multiplexed 7-segment display driver. The scanner debounces presses and shifts each accepted 4-bit key code into a 16-bit entry register; the upper and lower bytes serve as the two operands of the multiplier datapath. The display driver shows a 32-bit word as eight hex digits; the top level supplies `{operand X, operand Y, 16-bit product}`.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles per keypad column period.
- DEB_FRAMES, 4: consecutive identical scan frames required to accept a press or a release.
- DISP_DIV, 50000: clk cycles per display digit slot.

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge.
- clr  in  1  reset, synchronous, active-low.
- KEY_R  in  4  keypad rows, active-low (pulled up); KEY_R[i] is row i.
- KEY_C  out  4  keypad column drive, one-hot active-low; KEY_C[j] is column j.
- out  out  16  key entry register; newest key in out[3:0].
- press_times  out  3  accepted-press counter, wraps modulo 8.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- N  in  32  word to display; N[4k+3:4k] appears on digit k.
- seg  out  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high; dp is always 0.
- sel  out  3  binary index of the active digit.

## Operation
- Key code = 4*row + column (0x0–0xF).
- Column scan:
  - KEY_C rotates 0111 → 1011 → 1101 → 1110 → 0111, advancing every SCAN_DIV cycles.
  - The active column index is 3, 2, 1, 0 in that order.
- Row sampling:
  - KEY_R is sampled on the last cycle of each column period.
  - A row reading 0 means the key at (row, active column) is pressed.
- Frame result:
  - One frame is four column periods, ending after column 0.
  - frame_key is the lowest pressed code in the frame, or NONE if no key was pressed.
  - When several keys are pressed, the lowest code wins.
- Stability counter:
  - At each frame end, if frame_key equals the previous frame_key, stable_cnt increments, saturating at DEB_FRAMES.
  - Otherwise stable_cnt is set to 1.
- Press FSM has two states, IDLE and HELD:
  - IDLE → HELD when stable_cnt reaches DEB_FRAMES and frame_key ≠ NONE.
  - On that transition: out <= {out[11:0], code}, press_times increments, and key_valid pulses for 1 cycle.
  - HELD → IDLE when stable_cnt reaches DEB_FRAMES and frame_key = NONE.
  - In HELD, a held key or a different key produces no further acceptance; the FSM must pass through IDLE first.
- out wraps naturally: after four presses the oldest nibble is shifted out.
- Display:
  - A refresh counter advances sel every DISP_DIV cycles, 0 → 7 → 0.
  - seg and sel are registered together, so seg always shows the digit selected by the current sel.
  - seg shows the font pattern of N[4*sel+3:4*sel], sampled at the moment sel is updated.
- Font: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.

## Timing
- Reset values (clr=0 on a rising edge):
  - KEY_C = 0111, out = 0, press_times = 0, key_valid = 0.
  - Scan counters = 0, stable_cnt = 0, previous frame_key = NONE, FSM = IDLE.
  - sel = 0, seg = 00, refresh counter = 0.
- Reset asserted mid-scan or mid-press aborts everything. After release, a still-held key must again be stable for DEB_FRAMES frames before it is accepted.
- Press latency:
  - Measured from a key going down before a frame starts to the key_valid pulse.
  - It is DEB_FRAMES frames plus 1 cycle, i.e. DEB_FRAMES*4*SCAN_DIV + 1 cycles.
  - A press that begins mid-frame adds up to one frame.
- out and press_times update in the same cycle as key_valid.
- The first display update occurs DISP_DIV cycles after reset release, setting sel = 1 with seg for digit 1. The seg value for digit 0 is loaded on the wrap from 7.
- A change on N is reflected on the next sel update.

## Test plan
Use SCAN_DIV=4, DEB_FRAMES=2, DISP_DIV=4.
- Reset: hold clr=0 for 3 cycles, then release → KEY_C=0111, out=0000, press_times=0, sel=0, seg=00; KEY_C becomes 1011 after 4 cycles.
- Single press: assert row 1 low while column 2 is active, held for 5 frames, then release → exactly one key_valid pulse; out=0006, press_times=1.
- Sequence 1,2,3,4,5 (each pressed and released for 3 frames) → out=2345, press_times=5.
- Bounce: a key toggling every frame, then a release → no key_valid. Two keys 0x3 and 0x9 held together → code 3 accepted once.
- Display: N=0x1234ABCD → over 8 slots, sel=k shows the pattern of nibble k: D→5E, C→39, B→7C, A→77, 4→66, 3→4F, 2→5B, 1→06; sel wraps 7 → 0.
- Reset during HELD with the key still down → no key_valid for 2 frames after release; then exactly one acceptance.
